// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the EX-stage ALU.
// When idle the EX operands pass straight through to the ALU. On a request the
// sequencer takes over the ALU input mux and iterates using only add, sub and
// sltiu, holding stall high until the result is ready.
module alu_muldiv_seq #(
    parameter int unsigned         XLEN        = 32,
    parameter int unsigned         CNT_W       = 6,
    parameter int unsigned         ALUOP_W     = 5,
    parameter logic [ALUOP_W-1:0]  ALUOP_ADD   = 5'd0,
    parameter logic [ALUOP_W-1:0]  ALUOP_SUB   = 5'd1,
    parameter logic [ALUOP_W-1:0]  ALUOP_SLTIU = 5'd11
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [XLEN-1:0]    ex_A,
    input  logic [XLEN-1:0]    ex_B,
    input  logic [ALUOP_W-1:0] ex_ALUOp,
    input  logic               md_start,
    input  logic [1:0]         md_op,
    input  logic [XLEN-1:0]    md_a,
    input  logic [XLEN-1:0]    md_b,
    output logic [XLEN-1:0]    alu_A,
    output logic [XLEN-1:0]    alu_B,
    output logic [ALUOP_W-1:0] alu_ALUOp,
    input  logic [XLEN-1:0]    alu_C,
    output logic               stall,
    output logic               md_done,
    output logic [XLEN-1:0]    md_result
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivCmp,
        StDivSub,
        StDone
    } state_e;

    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRemu = 2'b10;

    state_e            r_state;
    state_e            w_state_nxt;

    logic [1:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_rs;
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_rs;
    logic              w_last;
    logic              w_req_div;
    logic              w_b_zero;
    logic              w_rem_top;
    logic              w_lt;
    logic [XLEN-1:0]   w_sel;

    // Shifted partial remainder; its 33rd bit is r_rem[XLEN-1].
    assign w_rs      = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    assign w_last    = (r_cnt == CNT_W'(XLEN - 1));
    assign w_req_div = (md_op == OpDivu) || (md_op == OpRemu);
    assign w_b_zero  = (md_b == '0);
    assign w_rem_top = r_rem[XLEN-1];
    assign w_lt      = alu_C[0];

    // Result selection; reserved op code 11 behaves as MUL.
    always_comb begin
        w_sel = r_acc;
        if (r_op == OpDivu) begin
            w_sel = r_q;
        end else if (r_op == OpRemu) begin
            w_sel = r_rem;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (md_start) begin
                    if (!w_req_div) begin
                        w_state_nxt = StMul;
                    end else if (w_b_zero) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StDivCmp;
                    end
                end
            end
            StMul: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDivCmp: begin
                if (w_rem_top || !w_lt) begin
                    w_state_nxt = StDivSub;
                end else if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDivSub: begin
                w_state_nxt = w_last ? StDone : StDivCmp;
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Datapath registers: operand latch, iteration and result hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op     <= 2'b00;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_rs     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (md_start) begin
                        r_op     <= md_op;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= md_a;
                        r_mplier <= md_b;
                        r_div    <= md_b;
                        // Divide by zero preloads the architectural results.
                        if (w_b_zero) begin
                            r_q   <= '1;
                            r_rem <= md_a;
                        end else begin
                            r_q   <= md_a;
                            r_rem <= '0;
                        end
                    end
                end
                StMul: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_C;
                    end
                    r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                StDivCmp: begin
                    if (!w_rem_top && w_lt) begin
                        r_rem <= w_rs;
                        r_q   <= {r_q[XLEN-2:0], 1'b0};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_rs  <= w_rs;
                    end
                end
                StDivSub: begin
                    r_rem <= alu_C;
                    r_q   <= {r_q[XLEN-2:0], 1'b1};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                StDone: begin
                    r_result <= w_sel;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: ALU mux ownership, stall, done pulse and result.
    always_comb begin
        alu_A     = ex_A;
        alu_B     = ex_B;
        alu_ALUOp = ex_ALUOp;
        case (r_state)
            StIdle: begin
                alu_A     = ex_A;
                alu_B     = ex_B;
                alu_ALUOp = ex_ALUOp;
            end
            StMul: begin
                alu_A     = r_acc;
                alu_B     = r_mcand;
                alu_ALUOp = ALUOP_ADD;
            end
            StDivCmp: begin
                // Shifted remainder >= 2^XLEN always subtracts; ALU idles.
                if (w_rem_top) begin
                    alu_A     = '0;
                    alu_B     = '0;
                    alu_ALUOp = ALUOP_ADD;
                end else begin
                    alu_A     = w_rs;
                    alu_B     = r_div;
                    alu_ALUOp = ALUOP_SLTIU;
                end
            end
            StDivSub: begin
                alu_A     = r_rs;
                alu_B     = r_div;
                alu_ALUOp = ALUOP_SUB;
            end
            default: begin
                alu_A     = '0;
                alu_B     = '0;
                alu_ALUOp = ALUOP_ADD;
            end
        endcase
        stall     = (r_state != StIdle);
        md_done   = (r_state == StDone);
        // Result is visible during the done cycle and held afterwards.
        md_result = (r_state == StDone) ? w_sel : r_result;
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU, arithmetic reference
// model for results and latency, randomized and directed operations.
module tb_alu_muldiv_seq;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLTIU = 5'd11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] ex_A = '0;
    logic [31:0] ex_B = '0;
    logic [4:0]  ex_ALUOp = '0;
    logic        md_start = 1'b0;
    logic [1:0]  md_op = '0;
    logic [31:0] md_a = '0;
    logic [31:0] md_b = '0;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [4:0]  alu_ALUOp;
    logic [31:0] alu_C;
    logic        stall;
    logic        md_done;
    logic [31:0] md_result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(
        .XLEN       (32),
        .CNT_W      (6),
        .ALUOP_W    (5),
        .ALUOP_ADD  (OP_ADD),
        .ALUOP_SUB  (OP_SUB),
        .ALUOP_SLTIU(OP_SLTIU)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ex_A     (ex_A),
        .ex_B     (ex_B),
        .ex_ALUOp (ex_ALUOp),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_ALUOp(alu_ALUOp),
        .alu_C    (alu_C),
        .stall    (stall),
        .md_done  (md_done),
        .md_result(md_result)
    );

    // Behavioural ALU.
    always_comb begin
        case (alu_ALUOp)
            OP_ADD:   alu_C = alu_A + alu_B;
            OP_SUB:   alu_C = alu_A - alu_B;
            OP_SLTIU: alu_C = {31'd0, (alu_A < alu_B)};
            default:  alu_C = '0;
        endcase
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        case (op)
            2'b01:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   r = (b == 0) ? a : a % b;
            default: r = a * b;
        endcase
        return r;
    endfunction

    // Restoring division spends one extra cycle on every quotient bit that is 1.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic [31:0] q;
        if (op == 2'b01 || op == 2'b10) begin
            if (b == 0) return 1;
            q = a / b;
            return 33 + $countones(q);
        end
        return 33;
    endfunction

    // Issue one request and observe it to completion (bounded wait).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ign_cyc, output logic [31:0] res, output int lat,
                          output int stall_bad, output logic [31:0] held,
                          output logic done_after);
        stall_bad = 0;
        res = '0;
        lat = -1;
        @(negedge clk);
        md_op = op;
        md_a = a;
        md_b = b;
        md_start = 1'b1;
        if (stall) stall_bad++;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        md_op = 2'($urandom);
        md_a = $urandom;
        md_b = $urandom;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (!stall) stall_bad++;
            if (md_done) begin
                res = md_result;
                lat = c;
                break;
            end
            md_start = (c == ign_cyc);
        end
        md_start = 1'b0;
        @(negedge clk);
        done_after = md_done;
        held = md_result;
        if (stall) stall_bad++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ex_A = 32'h1234_5678;
        ex_B = 32'h9abc_def0;
        ex_ALUOp = 5'd7;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        total++;
        if (md_done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", md_done);
        end
        total++;
        if (md_result !== 32'h0) begin
            bad++; $display("FAIL reset_result got=%h exp=0", md_result);
        end
        total++;
        if (alu_A !== ex_A || alu_B !== ex_B || alu_ALUOp !== ex_ALUOp) begin
            bad++;
            $display("FAIL reset_passthru got=%h/%h/%h exp=%h/%h/%h", alu_A, alu_B, alu_ALUOp,
                     ex_A, ex_B, ex_ALUOp);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  o;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 32'd5 : $urandom;
            b = (i == 0) ? 32'd3 : $urandom;
            o = (i == 0) ? OP_SUB : 5'($urandom);
            ex_A = a;
            ex_B = b;
            ex_ALUOp = o;
            #1;
            total++;
            if (alu_A !== a || alu_B !== b || alu_ALUOp !== o) begin
                bad++;
                $display("FAIL passthru got=%h/%h/%h exp=%h/%h/%h", alu_A, alu_B, alu_ALUOp,
                         a, b, o);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] ta[5] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd7, 32'hDEAD_BEEF, 32'd0};
        logic [31:0] tb[5] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd6, 32'h0000_1003, 32'd99};
        logic [1:0]  to[5] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        logic [31:0] res, held, exp;
        int lat, sb;
        logic da;
        for (int i = 0; i < 5; i++) begin
            run_op(to[i], ta[i], tb[i], 0, res, lat, sb, held, da);
            exp = ref_result(to[i], ta[i], tb[i]);
            total++;
            if (res !== exp) begin
                bad++; $display("FAIL mul_result a=%h b=%h got=%h exp=%h", ta[i], tb[i], res, exp);
            end
            total++;
            if (lat != 33) begin
                bad++; $display("FAIL mul_latency a=%h got=%0d exp=33", ta[i], lat);
            end
            total++;
            if (sb != 0) begin
                bad++; $display("FAIL mul_stall a=%h bad_cycles=%0d exp=0", ta[i], sb);
            end
            total++;
            if (da !== 1'b0 || held !== exp) begin
                bad++; $display("FAIL mul_hold done=%b held=%h exp=0/%h", da, held, exp);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta[6] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE,
                               32'hFFFF_FFFE};
        logic [31:0] tb[6] = '{32'd7, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001};
        logic [1:0]  to[6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        logic [31:0] res, held, exp;
        int lat, sb, el;
        logic da;
        for (int i = 0; i < 6; i++) begin
            run_op(to[i], ta[i], tb[i], 0, res, lat, sb, held, da);
            exp = ref_result(to[i], ta[i], tb[i]);
            el = ref_latency(to[i], ta[i], tb[i]);
            total++;
            if (res !== exp) begin
                bad++;
                $display("FAIL div_result op=%0d a=%h b=%h got=%h exp=%h", to[i], ta[i], tb[i],
                         res, exp);
            end
            total++;
            if (lat != el) begin
                bad++; $display("FAIL div_latency a=%h b=%h got=%0d exp=%0d", ta[i], tb[i], lat, el);
            end
            total++;
            if (sb != 0 || da !== 1'b0 || held !== exp) begin
                bad++;
                $display("FAIL div_stall_hold stall_bad=%0d done=%b held=%h exp=0/0/%h", sb, da,
                         held, exp);
            end
        end
    endtask

    task automatic test_divzero();
        logic [31:0] res, held, exp;
        int lat, sb;
        logic da;
        for (int i = 0; i < 2; i++) begin
            run_op((i == 0) ? 2'b01 : 2'b10, 32'd1234, 32'd0, 0, res, lat, sb, held, da);
            exp = (i == 0) ? 32'hFFFF_FFFF : 32'd1234;
            total++;
            if (res !== exp) begin
                bad++; $display("FAIL divzero_result i=%0d got=%h exp=%h", i, res, exp);
            end
            total++;
            if (lat != 1 || sb != 0) begin
                bad++; $display("FAIL divzero_latency i=%0d got=%0d/%0d exp=1/0", i, lat, sb);
            end
        end
    endtask

    task automatic test_ignore();
        logic [31:0] res, held, exp;
        int lat, sb;
        logic da;
        run_op(2'b00, 32'd123, 32'd456, 5, res, lat, sb, held, da);
        exp = 32'd56088;
        total++;
        if (res !== exp || lat != 33) begin
            bad++; $display("FAIL ignore_mul got=%h/%0d exp=%h/33", res, lat, exp);
        end
        run_op(2'b10, 32'd1000, 32'd37, 7, res, lat, sb, held, da);
        exp = 32'd1000 % 32'd37;
        total++;
        if (res !== exp || lat != ref_latency(2'b10, 32'd1000, 32'd37)) begin
            bad++; $display("FAIL ignore_rem got=%h/%0d exp=%h", res, lat, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, held;
        int lat, sb, seen;
        logic da;
        @(negedge clk);
        md_op = 2'b00;
        md_a = 32'd7;
        md_b = 32'd6;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || md_done !== 1'b0 || md_result !== 32'h0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b/%b/%h exp=0/0/0", stall, md_done, md_result);
        end
        total++;
        if (alu_A !== ex_A || alu_B !== ex_B || alu_ALUOp !== ex_ALUOp) begin
            bad++; $display("FAIL midreset_passthru got=%h/%h exp=%h/%h", alu_A, alu_B, ex_A, ex_B);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        ex_A = 32'hCAFE_0001;
        ex_B = 32'h0BAD_F00D;
        ex_ALUOp = OP_SLTIU;
        #1;
        total++;
        if (alu_A !== ex_A || alu_B !== ex_B || alu_ALUOp !== ex_ALUOp) begin
            bad++; $display("FAIL release_passthru got=%h/%h exp=%h/%h", alu_A, alu_B, ex_A, ex_B);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (md_done || stall) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL midreset_abort busy_cycles=%0d exp=0", seen);
        end
        run_op(2'b00, 32'd7, 32'd6, 0, res, lat, sb, held, da);
        total++;
        if (res !== 32'd42 || lat != 33) begin
            bad++; $display("FAIL midreset_recover got=%h/%0d exp=2a/33", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, held, exp;
        logic [1:0]  op;
        int lat, sb, el, mode;
        logic da;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            mode = $urandom_range(0, 5);
            b = (mode == 0) ? 32'd0 : (mode < 3) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(op, a, b, 0, res, lat, sb, held, da);
            exp = ref_result(op, a, b);
            el = ref_latency(op, a, b);
            total++;
            if (res !== exp || lat != el) begin
                bad++;
                $display("FAIL rand op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", op, a, b, res, lat,
                         exp, el);
            end
            total++;
            if (sb != 0 || da !== 1'b0 || held !== exp) begin
                bad++;
                $display("FAIL rand_hold op=%0d stall_bad=%0d done=%b held=%h exp=0/0/%h", op, sb,
                         da, held, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_mul();
        test_reset_mid();
        test_div();
        test_divzero();
        test_ignore();
        test_passthrough();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that owns the shared 32-bit ALU input mux in the EX stage.
- When idle it passes the EX-stage ALU operands/op straight through.
- On a mul/div request it takes the ALU over and iterates shift-add (MUL) or restoring division (DIVU/REMU) using only existing ALU ops (add, sub, sltiu), raising stall to freeze the pipeline until the result is ready.

Parameters:
- XLEN, 32, datapath width; only 32 supported, must match ALU.
- CNT_W, 6, iteration counter width (must hold XLEN).
- ALUOP_W, 5, ALUOp width; codes come from defines.v macros.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- ex_A  in  32  EX-stage ALU operand A (pass-through).
- ex_B  in  32  EX-stage ALU operand B (pass-through).
- ex_ALUOp  in  5  EX-stage ALU op (pass-through).
- md_start  in  1  one-cycle request pulse; sampled only in IDLE.
- md_op  in  2  00=MUL (low 32 bits), 01=DIVU (quotient), 10=REMU (remainder), 11=reserved (treated as MUL).
- md_a  in  32  multiplicand / dividend.
- md_b  in  32  multiplier / divisor.
- alu_A  out  32  to ALU A.
- alu_B  out  32  to ALU B.
- alu_ALUOp  out  5  to ALU ALUOp.
- alu_C  in  32  ALU result C.
- stall  out  1  high while the sequencer owns the ALU (state != IDLE).
- md_done  out  1  one-cycle pulse, result valid.
- md_result  out  32  result; held until next accepted md_start.

Behaviour:
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE. State/regs async-cleared on rstn=0.
- Reset: state=IDLE, md_done=0, md_result=0, stall=0, counter=0. Reset mid-operation aborts with no done pulse.
- IDLE: alu_A/B/ALUOp = ex_A/ex_B/ex_ALUOp combinationally.
- Accept: md_start=1 in IDLE latches md_a, md_b, md_op; counter=0; next state MUL or DIV_CMP. md_start outside IDLE is ignored.
- Divide by zero (md_b=0 on accept): go directly to DONE. Result: DIVU=32'hFFFFFFFF, REMU=md_a.
- MUL:
  - Registers acc=0, mcand=md_a, mplier=md_b.
  - Each cycle drives alu_A=acc, alu_B=mcand, ALUOp_add.
  - If mplier[0]=1, acc<=alu_C.
  - mcand<<=1, mplier>>=1, counter++.
  - After 32 cycles go to DONE.
- DIV, restoring, one quotient bit per iteration:
  - Setup: rem=0, q=md_a.
  - DIV_CMP:
    - Form rs={rem[30:0],q[31]}.
    - If rem[31]=1: shifted value exceeds 2^32, so force subtract; go to DIV_SUB, with ALU unused that cycle (drive ALUOp_add, zeros).
    - Else drive alu_A=rs, alu_B=divisor, ALUOp_sltiu; alu_C[0]=1 means rs<divisor.
      - If less: rem<=rs, q<={q[30:0],0}, counter++, stay in DIV_CMP.
      - Else: latch rs, go to DIV_SUB.
  - DIV_SUB: drive alu_A=rs, alu_B=divisor, ALUOp_sub; rem<=alu_C (32-bit wrap), q<={q[30:0],1}, counter++; return to DIV_CMP.
  - After 32 bits go to DONE.
- DONE:
  - md_result <= MUL: acc; DIVU: q; REMU: rem.
  - md_done=1 for exactly this cycle; stall=1 this cycle.
  - Next state IDLE.
- Latency from the accept edge to the md_done cycle:
  - MUL: 33 cycles.
  - DIV: 33 to 65 cycles (one extra per subtracted bit).
  - div-by-zero: 1 cycle.
- stall is registered-state-derived, glitch-free: stall=(state!=IDLE). It is low in the accept cycle itself; the pipeline must hold EX for the md instruction using md_start.
- Counter wrap: counter is compared to XLEN, never wraps in normal operation.

Test Plan:
- Reset mid-MUL: start MUL 7*6, assert rstn=0 at cycle 10 -> all outputs 0 immediately, state IDLE, no md_done; ex_* passes through after release.
- MUL 32'h0001_0001*32'h0001_0001 -> md_done at cycle 33, md_result=32'h0002_0001; stall high cycles 1..33; MUL 0xFFFFFFFF*0xFFFFFFFF -> 32'h0000_0001.
- DIVU 100/7 -> md_result=14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF (every bit subtracted, 64 cycles + done); DIVU 0x80000000/0xFFFFFFFF -> 0 (rem[31] forced-subtract path irrelevant) and 0xFFFFFFFE/0x80000001 -> 1.
- Divide by zero: DIVU 1234/0 -> done next cycle, 0xFFFFFFFF; REMU 1234/0 -> 1234.
- Pass-through and ignore: in IDLE, ex_A=5, ex_B=3, ex_ALUOp=sub -> alu_* equal inputs same cycle. Pulse md_start during busy -> ignored; the original result stays correct.
